// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus monitor.
// Covers command opcode masks, the screen image type and the error bit indices.
package lcd_pkg;

    typedef logic [0:31][7:0] frame_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEARING
    } state_t;

    localparam logic [7:0] SPACE      = 8'h20;
    localparam logic [6:0] LINE2_BASE = 7'h40;

    localparam int ERR_GLITCH = 0;
    localparam int ERR_BUSY   = 1;
    localparam int ERR_ADDR   = 2;

    localparam logic [7:0] CMD_DDRAM_M = 8'h80;
    localparam logic [7:0] CMD_DDRAM_V = 8'h80;
    localparam logic [7:0] CMD_CGRAM_M = 8'hC0;
    localparam logic [7:0] CMD_CGRAM_V = 8'h40;
    localparam logic [7:0] CMD_FUNC_M  = 8'hE0;
    localparam logic [7:0] CMD_FUNC_V  = 8'h20;
    localparam logic [7:0] CMD_SHIFT_M = 8'hF0;
    localparam logic [7:0] CMD_SHIFT_V = 8'h10;
    localparam logic [7:0] CMD_DISP_M  = 8'hF8;
    localparam logic [7:0] CMD_DISP_V  = 8'h08;
    localparam logic [7:0] CMD_ENTRY_M = 8'hFC;
    localparam logic [7:0] CMD_ENTRY_V = 8'h04;
    localparam logic [7:0] CMD_HOME_M  = 8'hFE;
    localparam logic [7:0] CMD_HOME_V  = 8'h02;
    localparam logic [7:0] CMD_CLEAR_M = 8'hFF;
    localparam logic [7:0] CMD_CLEAR_V = 8'h01;

    function automatic logic is_cmd(input logic [7:0] db,
                                    input logic [7:0] mask,
                                    input logic [7:0] val);
        return (db & mask) == val;
    endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Synchronizes the LCD bus, qualifies E pulse width and emits
// one-cycle transaction or glitch pulses on each falling edge of E.
module lcd_strobe_sync #(
    parameter int MIN_E_HIGH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [7:0] db_i,
    output logic       txn_valid_o,
    output logic       txn_glitch_o,
    output logic       txn_rs_o,
    output logic       txn_rw_o,
    output logic [7:0] txn_db_o
);

    localparam int CW = $clog2(MIN_E_HIGH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MIN_E_HIGH);

    logic [10:0]   s1_q, s2_q, s3_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall;
    logic          valid_q, glitch_q, rs_q, rw_q;
    logic [7:0]    db_q;

    // s3 lags s2 by one cycle, so on a fall it still holds pre-fall bus values
    assign fall = ~s2_q[10] & s3_q[10];

    always_comb begin
        cnt_d = '0;
        if (s2_q[10]) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            glitch_q <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            db_q     <= '0;
        end else begin
            s1_q     <= {e_i, rs_i, rw_i, db_i};
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            valid_q  <= fall && (cnt_q == CNT_MAX);
            glitch_q <= fall && (cnt_q != CNT_MAX);
            rs_q     <= s3_q[9];
            rw_q     <= s3_q[8];
            db_q     <= s3_q[7:0];
        end
    end

    assign txn_valid_o  = valid_q;
    assign txn_glitch_o = glitch_q;
    assign txn_rs_o     = rs_q;
    assign txn_rw_o     = rw_q;
    assign txn_db_o     = db_q;

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus monitor: decodes commands and data writes
// and rebuilds the two-line, 32-character screen image.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int MIN_E_HIGH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E,
    input  logic             RS,
    input  logic             RW,
    input  logic [7:0]       DB,
    output logic [0:31][7:0] Frame,
    output logic [4:0]       Cursor,
    output logic             DisplayOn,
    output logic             Busy,
    output logic             WriteStrobe,
    output logic             FrameDone,
    output logic [2:0]       ErrFlags
);

    logic       txn_valid, txn_glitch, txn_rs, txn_rw;
    logic [7:0] txn_db;

    state_t     state_q, state_d;
    logic [4:0] fill_q, fill_d;
    logic [4:0] cursor_q, cursor_d;
    logic       inc_q, inc_d;
    logic       disp_q, disp_d;
    logic       drop_q, drop_d;
    logic [2:0] err_q, err_d;
    frame_t     frame_q, frame_d;
    logic       wstb_q, wstb_d;
    logic       fdone_q, fdone_d;
    logic       wr_req;

    lcd_strobe_sync #(
        .MIN_E_HIGH(MIN_E_HIGH)
    ) u_sync (
        .clk         (clk),
        .reset       (reset),
        .e_i         (E),
        .rs_i        (RS),
        .rw_i        (RW),
        .db_i        (DB),
        .txn_valid_o (txn_valid),
        .txn_glitch_o(txn_glitch),
        .txn_rs_o    (txn_rs),
        .txn_rw_o    (txn_rw),
        .txn_db_o    (txn_db)
    );

    assign wr_req = txn_valid && !txn_rw;

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        cursor_d = cursor_q;
        inc_d    = inc_q;
        disp_d   = disp_q;
        drop_d   = drop_q;
        err_d    = err_q;
        frame_d  = frame_q;
        wstb_d   = 1'b0;
        fdone_d  = 1'b0;

        if (txn_glitch) begin
            err_d[ERR_GLITCH] = 1'b1;
        end

        case (state_q)
            ST_CLEARING: begin
                frame_d[fill_q] = SPACE;
                fill_d = fill_q + 5'd1;
                if (fill_q == 5'd31) begin
                    state_d = ST_IDLE;
                end
                if (wr_req) begin
                    err_d[ERR_BUSY] = 1'b1;
                end
            end
            ST_IDLE: begin
                if (wr_req && txn_rs) begin
                    if (!drop_q) begin
                        frame_d[cursor_q] = txn_db;
                        wstb_d   = 1'b1;
                        fdone_d  = (cursor_q == 5'd31);
                        cursor_d = inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
                    end
                end else if (wr_req) begin
                    if (is_cmd(txn_db, CMD_DDRAM_M, CMD_DDRAM_V)) begin
                        // Only the first 16 cells of each DDRAM line are visible
                        if (txn_db[6:4] == 3'b000) begin
                            cursor_d = {1'b0, txn_db[3:0]};
                            drop_d   = 1'b0;
                        end else if (txn_db[6:4] == LINE2_BASE[6:4]) begin
                            cursor_d = {1'b1, txn_db[3:0]};
                            drop_d   = 1'b0;
                        end else begin
                            err_d[ERR_ADDR] = 1'b1;
                            drop_d = 1'b1;
                        end
                    end else if (is_cmd(txn_db, CMD_CGRAM_M, CMD_CGRAM_V)) begin
                        drop_d = 1'b1;
                    end else if (is_cmd(txn_db, CMD_FUNC_M, CMD_FUNC_V) ||
                                 is_cmd(txn_db, CMD_SHIFT_M, CMD_SHIFT_V)) begin
                    end else if (is_cmd(txn_db, CMD_DISP_M, CMD_DISP_V)) begin
                        disp_d = txn_db[2];
                    end else if (is_cmd(txn_db, CMD_ENTRY_M, CMD_ENTRY_V)) begin
                        inc_d = txn_db[1];
                    end else if (is_cmd(txn_db, CMD_HOME_M, CMD_HOME_V)) begin
                        cursor_d = '0;
                        drop_d   = 1'b0;
                    end else if (is_cmd(txn_db, CMD_CLEAR_M, CMD_CLEAR_V)) begin
                        state_d  = ST_CLEARING;
                        fill_d   = '0;
                        cursor_d = '0;
                        inc_d    = 1'b1;
                        drop_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            fill_q   <= '0;
            cursor_q <= '0;
            inc_q    <= 1'b1;
            disp_q   <= 1'b0;
            drop_q   <= 1'b0;
            err_q    <= '0;
            frame_q  <= {32{SPACE}};
            wstb_q   <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            cursor_q <= cursor_d;
            inc_q    <= inc_d;
            disp_q   <= disp_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
            wstb_q   <= wstb_d;
            fdone_q  <= fdone_d;
        end
    end

    assign Frame       = frame_q;
    assign Cursor      = cursor_q;
    assign DisplayOn   = disp_q;
    assign Busy        = (state_q == ST_CLEARING);
    assign WriteStrobe = wstb_q;
    assign FrameDone   = fdone_q;
    assign ErrFlags    = err_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed plus randomized bench for lcd_bus_monitor with a
// command-level reference model of the screen image.
module tb_lcd_bus_monitor;

    localparam int MIN = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             E, RS, RW;
    logic [7:0]       DB;
    logic [0:31][7:0] Frame;
    logic [4:0]       Cursor;
    logic             DisplayOn, Busy, WriteStrobe, FrameDone;
    logic [2:0]       ErrFlags;

    int checks = 0;
    int errors = 0;

    int wstb_seen = 0;
    int fdone_seen = 0;
    int busy_cycles = 0;

    logic [7:0] m_frame [32];
    int         m_cur;
    bit         m_inc, m_drop, m_disp, m_busy;
    logic [2:0] m_err;
    int         m_wstb = 0;
    int         m_fdone = 0;

    lcd_bus_monitor #(.MIN_E_HIGH(MIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .E          (E),
        .RS         (RS),
        .RW         (RW),
        .DB         (DB),
        .Frame      (Frame),
        .Cursor     (Cursor),
        .DisplayOn  (DisplayOn),
        .Busy       (Busy),
        .WriteStrobe(WriteStrobe),
        .FrameDone  (FrameDone),
        .ErrFlags   (ErrFlags)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (WriteStrobe === 1'b1) wstb_seen++;
        if (FrameDone === 1'b1) fdone_seen++;
        if (Busy === 1'b1) busy_cycles++;
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_frame[i] = 8'h20;
        m_cur = 0;
        m_inc = 1;
        m_drop = 0;
        m_disp = 0;
        m_busy = 0;
        m_err = 3'b000;
    endtask

    task automatic model_txn(input logic rs, input logic rw,
                             input logic [7:0] db, input int hi,
                             output bit clr);
        int h;
        int addr;
        clr = 0;
        if (hi < MIN) begin
            m_err[0] = 1'b1;
            return;
        end
        if (rw) return;
        if (m_busy) begin
            m_err[1] = 1'b1;
            return;
        end
        if (rs) begin
            if (!m_drop) begin
                m_frame[m_cur] = db;
                m_wstb++;
                if (m_cur == 31) m_fdone++;
                m_cur = (m_cur + (m_inc ? 1 : 31)) % 32;
            end
            return;
        end
        h = -1;
        for (int b = 0; b < 8; b++) if (db[b]) h = b;
        addr = int'(db) - 128;
        case (h)
            7: begin
                if (addr < 16) begin
                    m_cur = addr;
                    m_drop = 0;
                end else if (addr >= 64 && addr < 80) begin
                    m_cur = addr - 64 + 16;
                    m_drop = 0;
                end else begin
                    m_err[2] = 1'b1;
                    m_drop = 1;
                end
            end
            6: m_drop = 1;
            3: m_disp = db[2];
            2: m_inc = db[1];
            1: begin
                m_cur = 0;
                m_drop = 0;
            end
            0: begin
                for (int i = 0; i < 32; i++) m_frame[i] = 8'h20;
                m_cur = 0;
                m_inc = 1;
                m_drop = 0;
                clr = 1;
            end
            default: ;
        endcase
    endtask

    task automatic bus_txn(input logic rs, input logic rw,
                           input logic [7:0] db, input int hi);
        @(negedge clk);
        RS = rs;
        RW = rw;
        DB = db;
        repeat (3) @(negedge clk);
        E = 1'b1;
        repeat (hi) @(negedge clk);
        E = 1'b0;
        @(negedge clk);
        DB = 8'($urandom);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_txn(input logic rs, input logic rw,
                          input logic [7:0] db, input int hi,
                          input bit wait_clr = 1);
        bit clr;
        model_txn(rs, rw, db, hi, clr);
        bus_txn(rs, rw, db, hi);
        if (clr) begin
            if (wait_clr) repeat (36) @(negedge clk);
            else m_busy = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag);
        logic [0:31][7:0] ef;
        for (int i = 0; i < 32; i++) ef[i] = m_frame[i];
        checks++;
        assert (Frame === ef) else begin
            errors++;
            $error("FAIL frame_%s: observed %h expected %h", tag, Frame, ef);
        end
    endtask

    task automatic chk_state(input string tag);
        chk_frame(tag);
        chk({"cursor_", tag}, 32'(Cursor), 32'(m_cur));
        chk({"err_", tag}, 32'(ErrFlags), 32'(m_err));
        chk({"disp_", tag}, 32'(DisplayOn), 32'(m_disp));
        chk({"wstb_", tag}, 32'(wstb_seen), 32'(m_wstb));
        chk({"fdone_", tag}, 32'(fdone_seen), 32'(m_fdone));
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) do_txn(1, 0, 8'(s[i]), 6);
    endtask

    initial begin
        int base;
        int r;
        logic [7:0] rdb;
        logic [7:0] picks [8];

        reset = 1'b1;
        E = 1'b0;
        RS = 1'b0;
        RW = 1'b0;
        DB = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk_state("reset");
        chk("busy_reset", 32'(Busy), 32'd0);
        chk("wstb_pin_reset", 32'(WriteStrobe), 32'd0);
        chk("fdone_pin_reset", 32'(FrameDone), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        base = busy_cycles;
        do_txn(0, 0, 8'h01, 6);
        chk("clear_busy_len", 32'(busy_cycles - base), 32'd32);
        chk("clear_busy_low", 32'(Busy), 32'd0);
        chk_state("clear");

        do_txn(0, 0, 8'h80, 6);
        write_str("P1: HU");
        chk_state("p1hu");

        do_txn(0, 0, 8'hCF, 6);
        do_txn(1, 0, "5", 6);
        do_txn(1, 0, "X", 6);
        chk_state("wrap31");

        do_txn(0, 0, 8'h04, 6);
        do_txn(0, 0, 8'h80, 6);
        do_txn(1, 0, "A", 6);
        chk_state("decrement");

        do_txn(0, 0, 8'h95, 6);
        do_txn(1, 0, "Z", 6);
        chk_state("badaddr");
        do_txn(0, 0, 8'h80, 6);
        do_txn(1, 0, "Z", 6);
        chk_state("recover");

        do_txn(0, 0, 8'h0C, 6);
        chk_state("dispon");

        picks = '{8'h02, 8'h03, 8'h01, 8'h00, 8'h20, 8'h1C, 8'h48, 8'h3F};
        for (int n = 0; n < 50; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: do_txn(1, 0, 8'($urandom_range(32, 126)), 6);
                4: do_txn(0, 0, 8'h80 | (($urandom_range(0, 1) != 0) ? 8'h40 : 8'h00)
                          | 8'($urandom_range(0, 15)), 6);
                5: do_txn(0, 0, 8'h80 | 8'($urandom_range(0, 127)), 6);
                6: do_txn(0, 0, 8'h04 | 8'($urandom_range(0, 3)), 6);
                7: do_txn(0, 0, 8'h08 | 8'($urandom_range(0, 7)), 6);
                8: begin
                    rdb = picks[$urandom_range(0, 7)];
                    do_txn(0, 0, rdb, 6);
                end
                default: do_txn(1'($urandom), 1, 8'($urandom), 6);
            endcase
            chk_state("random");
        end

        do_txn(0, 0, 8'h80, 6);
        do_txn(1, 0, 8'h41, 2);
        chk_state("glitch");

        do_txn(0, 0, 8'h01, 6, 0);
        do_txn(0, 0, 8'h02, 6);
        repeat (40) @(negedge clk);
        m_busy = 0;
        chk_state("busy_err");

        do_txn(0, 0, 8'hCF, 6);
        do_txn(1, 0, "Q", 6);
        do_txn(0, 0, 8'h0C, 6);
        chk_state("preclear");
        do_txn(0, 0, 8'h01, 6, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        chk_state("midclear_reset");
        chk("busy_midclear", 32'(Busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base = busy_cycles;
        repeat (40) @(negedge clk);
        chk("busy_after_reset", 32'(busy_cycles - base), 32'd0);
        chk_state("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_monitor.md
# lcd_bus_monitor

Passive receiver for the HD44780-style LCD bus (E, RS, RW, DB[7:0]) that the score display path drives. It samples the bus, decodes commands and data writes, and rebuilds the 32-character screen image (two lines of 16) as a register array. It sits beside the LCD pins, for on-chip display mirroring and for self-checking the driver in simulation. It never drives the bus.

## Interface
- MIN_E_HIGH, default 4: minimum E high width in clk cycles. Shorter pulses are treated as glitches.
- clk  in  1  master 50 MHz clock
- reset  in  1  asynchronous, active-high reset
- E  in  1  LCD enable strobe. Asynchronous to clk.
- RS  in  1  register select: 0 = command, 1 = data
- RW  in  1  read/write: 1 = read cycle, which is ignored
- DB  in  8  LCD data bus
- Frame  out  32x8  screen image, index 0–15 = line 1, index 16–31 = line 2, ASCII codes
- Cursor  out  5  current write index, 0–31
- DisplayOn  out  1  D bit from the last display-control command
- Busy  out  1  high while a clear fill is in progress
- WriteStrobe  out  1  one-cycle pulse per accepted data write
- FrameDone  out  1  one-cycle pulse when index 31 is written
- ErrFlags  out  3  sticky error bits: [0] glitch, [1] write while busy, [2] invalid DDRAM address. Cleared only by reset.

## Operation
- **Input sampling.** E, RS, RW and DB pass through a two-flop synchronizer, then one delay stage.
- **Latch point.** The bus transaction is latched on the synchronized falling edge of E. RS, RW and DB are taken from the delay stage, which holds the values present before the fall.
- **E high-width counter.** It counts cycles while synchronized E is high and saturates at MIN_E_HIGH.
  - A fall with count < MIN_E_HIGH: the transaction is ignored and ErrFlags[0] is set.
- **Read cycles.** A fall with RW=1 is ignored. No flags change.
- **Commands (RS=0), priority by highest set bit of DB:**
  - 1xxxxxxx, set DDRAM address:
    - 0x00–0x0F maps to Cursor 0–15.
    - 0x40–0x4F maps to Cursor 16–31.
    - Any other address sets ErrFlags[2] and enters the drop state. Data writes are discarded until the next valid address, clear, or home command.
  - 01xxxxxx, set CGRAM address: enters the drop state without flagging.
  - 001xxxxx (function set) and 0001xxxx (shift): accepted, no effect.
  - 00001DCB: DisplayOn <= D.
  - 000001IS: IncMode <= I. S is ignored.
  - 0000001x, home: Cursor <= 0, leaves the drop state.
  - 00000001, clear: enter CLEARING, Cursor <= 0, IncMode <= 1, leaves the drop state.
  - 0x00: no effect.
- **Data write (RS=1), when not in the drop state:**
  - Frame[Cursor] <= DB.
  - WriteStrobe pulses.
  - Cursor steps +1 (IncMode=1) or −1 (IncMode=0), modulo 32. So 31 wraps to 0 and 0 wraps to 31, with no gap between lines.
- **FrameDone** pulses on any accepted write to index 31, in either direction.
- **States:**
  - IDLE: decodes transactions.
  - CLEARING: a 5-bit fill counter writes 0x20 to one index per cycle, 0→31, so it lasts 32 cycles. Busy=1. It then returns to IDLE.
- **Transaction during CLEARING:** dropped and ErrFlags[1] set, unless RW=1.
- **Reset mid-operation** (including mid-clear): all state returns to reset values at once.
- **Reset values:**
  - Frame all 0x20, Cursor 0, IncMode 1.
  - DisplayOn 0, Busy 0, WriteStrobe 0, FrameDone 0, ErrFlags 0.
  - Drop state off, state IDLE, synchronizers 0.

## Timing
- **Latency.** Let k be the clk edge where synchronizer stage 1 first captures E=0.
  - Falling-edge detection is valid after edge k+2.
  - Frame and Cursor update at edge k+3.
  - WriteStrobe and FrameDone are high for the cycle following edge k+3.
- **Command latency:** the same k+3 update.
- **CLEARING timing:**
  - Busy rises at k+3.
  - Index n is written at edge k+4+n.
  - Busy falls at edge k+35.
- **Setup requirement.** RS, RW and DB must be stable for at least 3 clk cycles before E falls and 1 cycle after.
- **Back-to-back transactions:** one per E pulse. The minimum E period is MIN_E_HIGH + 2 low cycles.

## Structure
- **Package lcd_pkg:**
  - typedef frame_t as logic [0:31][7:0].
  - Command opcode masks and values.
  - SPACE = 8'h20.
  - LINE2_BASE = 7'h40.
  - Error bit index constants.
- **Sub-module lcd_strobe_sync:**
  - Synchronizes the 11 bus bits.
  - Provides the delayed copy.
  - Contains the E width counter.
  - Outputs a one-cycle `txn_valid` / `txn_glitch` pulse with the captured RS, RW and DB.
- **Top level:** the decode FSM (IDLE/CLEARING), Cursor and IncMode logic, and the Frame register array.

## Test plan
- After reset, issue 0x01 (clear) -> Busy high for exactly 32 cycles, Frame all 0x20, Cursor 0.
- Issue 0x80, then write "P1: HU" -> Frame[0:5]="P1: HU", 6 WriteStrobe pulses, Cursor 6.
- Issue 0xCF, then write '5' then 'X' -> Frame[31]='5', FrameDone pulse, Frame[0]='X', Cursor 1.
- Issue 0x04 (decrement), 0x80, then write 'A' -> Frame[0]='A', Cursor 31.
- Issue 0x95 (invalid address) then write 'Z' -> ErrFlags[2]=1, Frame unchanged. Then 0x80 and 'Z' -> Frame[0]='Z'.
- E pulse of 2 cycles with DB=0x41 -> ErrFlags[0]=1, no write. Command during CLEARING -> ErrFlags[1]=1. Assert reset mid-clear -> all reset values.
